// File: rtl/acc_offload_arbiter_pkg.sv
// rtl/acc_offload_arbiter_pkg.sv - arbiter-local types.
package acc_offload_arbiter_pkg;

  typedef enum logic {
    ArbUnlocked = 1'b0,
    ArbLocked   = 1'b1
  } arb_state_e;

endpackage

// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - accelerator interconnect payload types and system defaults.
package acc_pkg;

  localparam int unsigned NumRsp      = 2;
  localparam int unsigned RspIdWidth  = (NumRsp > 1) ? $clog2(NumRsp) : 1;
  localparam int unsigned AccArbDepth = 4;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } acc_x_req_chan_t;

  typedef struct packed {
    logic [31:0]           data;
    logic [RspIdWidth-1:0] id;
    logic                  error;
  } acc_x_rsp_chan_t;

endpackage

// File: rtl/cf_math_pkg.sv
// rtl/cf_math_pkg.sv - index-width helper shared by arbiters and muxes.
package cf_math_pkg;

  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - synchronous FIFO with optional fall-through and fill level.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  dtype                  data_i,
  input  logic                  push_i,
  output dtype                  data_o,
  input  logic                  pop_i
);

  localparam int unsigned CntW = ADDR_DEPTH + 1;

  logic [ADDR_DEPTH-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]       cnt_q;
  dtype                  mem_q [DEPTH];
  logic                  bypass, push_ok, pop_ok;

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0) & ~(FALL_THROUGH & push_i);
  assign usage_o = cnt_q[ADDR_DEPTH-1:0];
  assign bypass  = FALL_THROUGH && (cnt_q == '0) && push_i && pop_i;
  assign push_ok = push_i & ~full_o & ~bypass;
  assign pop_ok  = pop_i & ~empty_o & ~bypass;
  assign data_o  = (FALL_THROUGH && (cnt_q == '0)) ? data_i : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= (wr_ptr_q == ADDR_DEPTH'(DEPTH - 1)) ? '0 : wr_ptr_q + ADDR_DEPTH'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= (rd_ptr_q == ADDR_DEPTH'(DEPTH - 1)) ? '0 : rd_ptr_q + ADDR_DEPTH'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/acc_offload_arbiter.sv
// rtl/acc_offload_arbiter.sv - round-robin offload arbiter with in-order response routing.
module acc_offload_arbiter
  import acc_offload_arbiter_pkg::*;
#(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned Depth    = acc_pkg::AccArbDepth,
  parameter type         req_t    = acc_pkg::acc_x_req_chan_t,
  parameter type         rsp_t    = acc_pkg::acc_x_rsp_chan_t,
  parameter int unsigned IdxWidth = cf_math_pkg::idx_width(NumReq)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumReq-1:0]            slv_q_valid_i,
  output logic [NumReq-1:0]            slv_q_ready_o,
  input  req_t [NumReq-1:0]            slv_q_i,
  input  logic [NumReq-1:0]            slv_q_wb_i,
  output logic                         mst_q_valid_o,
  input  logic                         mst_q_ready_i,
  output req_t                         mst_q_o,
  input  logic                         mst_p_valid_i,
  output logic                         mst_p_ready_o,
  input  rsp_t                         mst_p_i,
  output logic [NumReq-1:0]            slv_p_valid_o,
  input  logic [NumReq-1:0]            slv_p_ready_i,
  output rsp_t                         slv_p_o,
  output logic [$clog2(Depth+1)-1:0]   outstanding_o,
  output logic                         err_o
);

  localparam int unsigned CntWidth = $clog2(Depth + 1);
  localparam int unsigned FifoAw   = (Depth > 1) ? $clog2(Depth) : 1;

  arb_state_e          state_q;
  logic [IdxWidth-1:0] rr_q, lidx_q;
  logic                err_q;

  logic [IdxWidth-1:0] grant, grant_rr, grant_next, fifo_head;
  logic [IdxWidth:0]   rr_sum;
  logic [NumReq-1:0]   cand;
  logic                found, q_valid, q_hs, push, pop, rsp_active;
  logic                fifo_full, fifo_empty;
  logic [FifoAw-1:0]   fifo_usage;

  // A full ID queue hides writeback requests; a same-cycle pop does not unmask them.
  assign cand = slv_q_valid_i & ~(slv_q_wb_i & {NumReq{fifo_full}});

  always_comb begin
    grant_rr = '0;
    found    = 1'b0;
    rr_sum   = '0;
    for (int off = 0; off < NumReq; off++) begin
      rr_sum = {1'b0, rr_q} + (IdxWidth+1)'(off);
      if (rr_sum >= (IdxWidth+1)'(NumReq)) begin
        rr_sum = rr_sum - (IdxWidth+1)'(NumReq);
      end
      if (!found && cand[rr_sum[IdxWidth-1:0]]) begin
        found    = 1'b1;
        grant_rr = rr_sum[IdxWidth-1:0];
      end
    end
  end

  assign grant      = (state_q == ArbLocked) ? lidx_q : grant_rr;
  assign q_valid    = (state_q == ArbLocked) ? slv_q_valid_i[lidx_q] : found;
  assign q_hs       = q_valid & mst_q_ready_i;
  assign grant_next = (grant == IdxWidth'(NumReq - 1)) ? '0 : grant + IdxWidth'(1);
  assign push       = q_hs & slv_q_wb_i[grant];

  assign mst_q_valid_o = rst_ni & q_valid;
  assign mst_q_o       = slv_q_i[grant];

  always_comb begin
    slv_q_ready_o        = '0;
    slv_q_ready_o[grant] = rst_ni & q_hs;
  end

  assign rsp_active    = rst_ni & ~fifo_empty;
  assign mst_p_ready_o = rsp_active & slv_p_ready_i[fifo_head];
  assign pop           = mst_p_valid_i & mst_p_ready_o;
  assign slv_p_o       = mst_p_i;

  always_comb begin
    slv_p_valid_o            = '0;
    slv_p_valid_o[fifo_head] = rsp_active & mst_p_valid_i;
  end

  assign outstanding_o = fifo_full ? CntWidth'(Depth) : CntWidth'(fifo_usage);
  assign err_o         = err_q;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (IdxWidth),
    .DEPTH        (Depth)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage),
    .data_i  (grant),
    .push_i  (push),
    .data_o  (fifo_head),
    .pop_i   (pop)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ArbUnlocked;
      rr_q    <= '0;
      lidx_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (fifo_empty && mst_p_valid_i) begin
        err_q <= 1'b1;
      end
      case (state_q)
        ArbUnlocked: begin
          if (q_valid) begin
            if (mst_q_ready_i) begin
              rr_q <= grant_next;
            end else begin
              state_q <= ArbLocked;
              lidx_q  <= grant;
            end
          end
        end
        ArbLocked: begin
          if (!slv_q_valid_i[lidx_q]) begin
            err_q   <= 1'b1;
            state_q <= ArbUnlocked;
          end else if (mst_q_ready_i) begin
            rr_q    <= grant_next;
            state_q <= ArbUnlocked;
          end
        end
      endcase
    end
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(slv_p_valid_o));
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && fifo_full));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == ArbLocked && slv_q_valid_i[lidx_q]) |-> $stable(mst_q_o));

endmodule

// File: tb/tb_acc_offload_arbiter.sv
// tb/tb_acc_offload_arbiter.sv - directed vector bench for acc_offload_arbiter.
module tb_acc_offload_arbiter;
  import acc_pkg::*;

  localparam logic [31:0] RspData = 32'hFEED_0001;

  typedef struct {
    logic [3:0] qv, wb;
    logic       qr, pv;
    logic [3:0] pr;
    logic       e_mv;
    int         e_g;
    logic [3:0] e_qrdy, e_pval;
    logic       e_prdy;
    int         e_out;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] q_valid, q_wb, p_ready;
  logic q_ready, p_valid;
  acc_x_req_chan_t [3:0] slv_q;
  acc_x_rsp_chan_t mst_p;

  logic [3:0] a_q_ready, a_p_valid, b_q_ready, b_p_valid;
  logic a_mst_q_valid, a_mst_p_ready, a_err, b_mst_q_valid, b_mst_p_ready, b_err;
  acc_x_req_chan_t a_mst_q, b_mst_q;
  acc_x_rsp_chan_t a_slv_p, b_slv_p;
  logic [2:0] a_out;
  logic [1:0] b_out;

  int n_chk = 0;
  int n_fail = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  acc_offload_arbiter #(.NumReq(4), .Depth(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_q_valid_i(q_valid), .slv_q_ready_o(a_q_ready), .slv_q_i(slv_q), .slv_q_wb_i(q_wb),
    .mst_q_valid_o(a_mst_q_valid), .mst_q_ready_i(q_ready), .mst_q_o(a_mst_q),
    .mst_p_valid_i(p_valid), .mst_p_ready_o(a_mst_p_ready), .mst_p_i(mst_p),
    .slv_p_valid_o(a_p_valid), .slv_p_ready_i(p_ready), .slv_p_o(a_slv_p),
    .outstanding_o(a_out), .err_o(a_err)
  );

  acc_offload_arbiter #(.NumReq(4), .Depth(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_q_valid_i(q_valid), .slv_q_ready_o(b_q_ready), .slv_q_i(slv_q), .slv_q_wb_i(q_wb),
    .mst_q_valid_o(b_mst_q_valid), .mst_q_ready_i(q_ready), .mst_q_o(b_mst_q),
    .mst_p_valid_i(p_valid), .mst_p_ready_o(b_mst_p_ready), .mst_p_i(mst_p),
    .slv_p_valid_o(b_p_valid), .slv_p_ready_i(p_ready), .slv_p_o(b_slv_p),
    .outstanding_o(b_out), .err_o(b_err)
  );

  function automatic logic [31:0] pay(input int g);
    return 32'hA000_0000 + 32'(g);
  endfunction

  function automatic vec_t mk(input logic [3:0] qv, input logic [3:0] wb, input logic qr,
                              input logic pv, input logic [3:0] pr, input logic e_mv,
                              input int e_g, input logic [3:0] e_qrdy, input logic [3:0] e_pval,
                              input logic e_prdy, input int e_out);
    vec_t v;
    v.qv = qv; v.wb = wb; v.qr = qr; v.pv = pv; v.pr = pr;
    v.e_mv = e_mv; v.e_g = e_g; v.e_qrdy = e_qrdy; v.e_pval = e_pval;
    v.e_prdy = e_prdy; v.e_out = e_out;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] qv, input logic [3:0] wb, input logic qr,
                       input logic pv, input logic [3:0] pr);
    q_valid = qv; q_wb = wb; q_ready = qr; p_valid = pv; p_ready = pr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(4'h0, 4'h0, 1'b0, 1'b0, 4'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic apply(input vec_t v, input int k);
    drive(v.qv, v.wb, v.qr, v.pv, v.pr);
    #4;
    chk($sformatf("v%0d mst_q_valid", k), 32'(a_mst_q_valid), 32'(v.e_mv));
    if (v.e_mv) chk($sformatf("v%0d mst_q_o", k), a_mst_q.insn, pay(v.e_g));
    chk($sformatf("v%0d slv_q_ready", k), 32'(a_q_ready), 32'(v.e_qrdy));
    chk($sformatf("v%0d slv_p_valid", k), 32'(a_p_valid), 32'(v.e_pval));
    chk($sformatf("v%0d mst_p_ready", k), 32'(a_mst_p_ready), 32'(v.e_prdy));
    chk($sformatf("v%0d outstanding", k), 32'(a_out), 32'(v.e_out));
    chk($sformatf("v%0d err", k), 32'(a_err), 32'd0);
    if (v.e_pval != 4'h0) chk($sformatf("v%0d slv_p_o", k), a_slv_p.data, RspData);
    step();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      slv_q[i].insn = pay(i);
      slv_q[i].rs1  = 32'h100 + 32'(i);
      slv_q[i].rs2  = 32'h200 + 32'(i);
    end
    mst_p.data  = RspData;
    mst_p.id    = '0;
    mst_p.error = 1'b0;

    // qv wb qr pv pr | mv g qrdy pval prdy out
    vecs.push_back(mk(4'h0, 4'h0, 0, 0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0));
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(4'hF, 4'h0, 1, 0, 4'h0, 1, k % 4, 4'(1 << (k % 4)), 4'h0, 0, 0));
    vecs.push_back(mk(4'h8, 4'h8, 1, 0, 4'h0, 1, 3, 4'h8, 4'h0, 0, 0));
    vecs.push_back(mk(4'h2, 4'h2, 1, 0, 4'h0, 1, 1, 4'h2, 4'h0, 0, 1));
    vecs.push_back(mk(4'h8, 4'h8, 1, 0, 4'h0, 1, 3, 4'h8, 4'h0, 0, 2));
    vecs.push_back(mk(4'h0, 4'h0, 0, 1, 4'h7, 0, 0, 4'h0, 4'h8, 0, 3));
    vecs.push_back(mk(4'h1, 4'h1, 1, 1, 4'hF, 1, 0, 4'h1, 4'h8, 1, 3));
    vecs.push_back(mk(4'h0, 4'h0, 0, 1, 4'hF, 0, 0, 4'h0, 4'h2, 1, 3));
    vecs.push_back(mk(4'h0, 4'h0, 0, 1, 4'hF, 0, 0, 4'h0, 4'h8, 1, 2));
    vecs.push_back(mk(4'h0, 4'h0, 0, 1, 4'hF, 0, 0, 4'h0, 4'h1, 1, 1));
    vecs.push_back(mk(4'h0, 4'h0, 0, 0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0));
    vecs.push_back(mk(4'h4, 4'h0, 1, 0, 4'h0, 1, 2, 4'h4, 4'h0, 0, 0));
    vecs.push_back(mk(4'h4, 4'h0, 0, 0, 4'h0, 1, 2, 4'h0, 4'h0, 0, 0));
    vecs.push_back(mk(4'h5, 4'h0, 0, 0, 4'h0, 1, 2, 4'h0, 4'h0, 0, 0));
    vecs.push_back(mk(4'h5, 4'h0, 0, 0, 4'h0, 1, 2, 4'h0, 4'h0, 0, 0));
    vecs.push_back(mk(4'h5, 4'h0, 1, 0, 4'h0, 1, 2, 4'h4, 4'h0, 0, 0));
    vecs.push_back(mk(4'h1, 4'h0, 1, 0, 4'h0, 1, 0, 4'h1, 4'h0, 0, 0));

    do_reset();
    foreach (vecs[k]) apply(vecs[k], k);

    // Depth-2 instance: full queue masks writeback requests only.
    do_reset();
    drive(4'h1, 4'h1, 1, 0, 4'h0); #4 chk("full push0 ready", 32'(b_q_ready), 32'h1); step();
    drive(4'h2, 4'h2, 1, 0, 4'h0); #4 chk("full push1 ready", 32'(b_q_ready), 32'h2); step();
    drive(4'h1, 4'h1, 1, 0, 4'h0); #4
    chk("full outstanding", 32'(b_out), 32'd2);
    chk("full mask valid", 32'(b_mst_q_valid), 32'd0);
    chk("full mask ready", 32'(b_q_ready), 32'h0);
    step();
    drive(4'h3, 4'h1, 1, 0, 4'h0); #4
    chk("full nowb ready", 32'(b_q_ready), 32'h2);
    chk("full nowb payload", b_mst_q.insn, pay(1));
    step();
    drive(4'h1, 4'h1, 1, 1, 4'hF); #4
    chk("full pop pvalid", 32'(b_p_valid), 32'h1);
    chk("full pop pready", 32'(b_mst_p_ready), 32'd1);
    chk("full no bypass", 32'(b_q_ready), 32'h0);
    step();
    drive(4'h1, 4'h1, 1, 0, 4'h0); #4
    chk("full after pop out", 32'(b_out), 32'd1);
    chk("full after pop ready", 32'(b_q_ready), 32'h1);
    step();

    // Response while nothing is outstanding.
    do_reset();
    drive(4'h0, 4'h0, 0, 1, 4'hF); #4
    chk("err empty pready", 32'(a_mst_p_ready), 32'd0);
    chk("err empty pvalid", 32'(a_p_valid), 32'h0);
    chk("err before", 32'(a_err), 32'd0);
    step();
    drive(4'h0, 4'h0, 0, 0, 4'h0); #4 chk("err empty sticky", 32'(a_err), 32'd1); step();
    do_reset();
    #4 chk("err cleared by reset", 32'(a_err), 32'd0); step();

    // Locked core drops valid.
    drive(4'h2, 4'h0, 0, 0, 4'h0); #4 chk("drop lock valid", 32'(a_mst_q_valid), 32'd1); step();
    drive(4'h0, 4'h0, 0, 0, 4'h0); #4 chk("drop err pending", 32'(a_err), 32'd0); step();
    #4 chk("drop err set", 32'(a_err), 32'd1); step();

    // Asynchronous reset with two outstanding and the arbiter locked.
    do_reset();
    drive(4'h1, 4'h1, 1, 0, 4'h0); step();
    drive(4'h2, 4'h2, 1, 0, 4'h0); step();
    drive(4'h8, 4'h0, 0, 0, 4'h0); #4 chk("rst lock grant", a_mst_q.insn, pay(3)); step();
    drive(4'hF, 4'h0, 1, 1, 4'hF); #1
    chk("rst pre outstanding", 32'(a_out), 32'd2);
    chk("rst pre locked grant", a_mst_q.insn, pay(3));
    chk("rst pre ready", 32'(a_q_ready), 32'h8);
    #1 rst_n = 1'b0;
    #1
    chk("rst mst_q_valid", 32'(a_mst_q_valid), 32'd0);
    chk("rst slv_q_ready", 32'(a_q_ready), 32'h0);
    chk("rst slv_p_valid", 32'(a_p_valid), 32'h0);
    chk("rst mst_p_ready", 32'(a_mst_p_ready), 32'd0);
    chk("rst outstanding", 32'(a_out), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(4'hF, 4'h0, 1, 0, 4'h0); #4
    chk("rst release grant", a_mst_q.insn, pay(0));
    chk("rst release ready", 32'(a_q_ready), 32'h1);
    chk("rst release err", 32'(a_err), 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
